// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller slice.
package irq_pkg;

   localparam int unsigned IRQ_NSRC = 8;
   localparam int unsigned IRQ_IDW  = $clog2(IRQ_NSRC);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_SERVICE = 2'b10
   } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int unsigned NSRC = IRQ_NSRC,
   parameter int unsigned IDW  = IRQ_IDW
) (
   input  logic [NSRC-1:0] req,
   output logic [IDW-1:0]  idx,
   output logic            valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (req[i] && !valid) begin
            idx   = IDW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Priority interrupt controller with IDLE/REQ/SERVICE handshake to the core.
// Define IRQ_EDGE_EN for edge-detected sticky pending bits; default is level mode.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned NSRC = IRQ_NSRC,
   parameter int unsigned IDW  = IRQ_IDW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic [NSRC-1:0] irq_mask,
   input  logic            eoi,
   input  logic            IACK,
   output logic            I_Req,
   output logic [IDW-1:0]  irq_id,
   output logic [NSRC-1:0] irq_pending,
   output logic            irq_busy,
   output logic [15:0]     irq_count
);

   irq_state_e      state_q, state_d;
   logic [NSRC-1:0] sync1_q, sync2_q;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_masked;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  enc_idx;
   logic            enc_valid;
   logic            ireq_q;
   logic            eoi_stk_q, eoi_stk_d;
   logic [15:0]     count_q, count_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
      end
   end

`ifdef IRQ_EDGE_EN
   logic [NSRC-1:0] sync3_q, pend_q, clr;

   always_comb begin
      clr = '0;
      if ((state_q == ST_REQ) && IACK) begin
         clr[id_q] = 1'b1;
      end
   end

   // A fresh edge on the bit being acknowledged survives the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync3_q <= '0;
         pend_q  <= '0;
      end else begin
         sync3_q <= sync2_q;
         pend_q  <= (pend_q & ~clr) | (sync2_q & ~sync3_q);
      end
   end

   assign pend = pend_q;
`else
   assign pend = sync2_q;
`endif

   assign pend_masked = pend & irq_mask;

   irq_prio_enc #(
      .NSRC (NSRC),
      .IDW  (IDW)
   ) u_prio_enc (
      .req   (pend_masked),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      count_d   = count_q;
      eoi_stk_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enc_valid) begin
               state_d = ST_REQ;
               id_d    = enc_idx;
            end
         end
         ST_REQ: begin
            if (IACK) begin
               state_d = ST_SERVICE;
               count_d = count_q + 16'd1;
            end
         end
         ST_SERVICE: begin
            // eoi arriving while IACK is still high is remembered until IACK drops
            if ((eoi || eoi_stk_q) && !IACK) begin
               state_d = ST_IDLE;
            end else begin
               eoi_stk_d = eoi_stk_q || eoi;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         count_q   <= '0;
         eoi_stk_q <= 1'b0;
         ireq_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         count_q   <= count_d;
         eoi_stk_q <= eoi_stk_d;
         ireq_q    <= (state_d == ST_REQ);
      end
   end

   assign I_Req       = ireq_q;
   assign irq_id      = id_q;
   assign irq_pending = pend;
   assign irq_busy    = (state_q == ST_REQ) || (state_q == ST_SERVICE);
   assign irq_count   = count_q;

endmodule
